// File: rtl/button_event_pkg.sv
// Shared types for the button input-conditioning blocks: FSM state encoding,
// counter width and the event-pulse bundle.
package button_event_pkg;

  localparam int CNT_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
  } btn_state_e;

  typedef struct packed {
    logic press;
    logic rel;
    logic lng;
    logic rpt;
  } btn_evt_t;

  localparam btn_evt_t EVT_NONE = '{press: 1'b0, rel: 1'b0, lng: 1'b0, rpt: 1'b0};

  // Terminal count for a period of N cycles.
  function automatic logic [CNT_W-1:0] cnt_last(input logic [CNT_W-1:0] period);
    return period - {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/button_event.sv
// Press / release / long-press / auto-repeat event generator. All outputs are registered and follow the sampling edge by one cycle.
// No backpressure: events are one-cycle pulses and are dropped if not observed.
module button_event
  import button_event_pkg::*;
#(
  parameter logic [CNT_W-1:0] LONG_CYCLES   = 24'd1000000,
  parameter logic [CNT_W-1:0] REPEAT_CYCLES = 24'd250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_level,
  input  logic       repeat_en,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic       long_active,
  output logic [7:0] press_count
);

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  btn_evt_t         evt_q, evt_d;
  logic [7:0]       count_q, count_d;
  logic             held_q, held_d;
  logic             long_act_q, long_act_d;

  logic long_hit;
  logic rpt_hit;

  assign long_hit = (cnt_q == cnt_last(LONG_CYCLES));
  assign rpt_hit  = (cnt_q == cnt_last(REPEAT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      evt_q      <= EVT_NONE;
      count_q    <= 8'd0;
      held_q     <= 1'b0;
      long_act_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      evt_q      <= evt_d;
      count_q    <= count_d;
      held_q     <= held_d;
      long_act_q <= long_act_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (btn_level) state_d = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (!btn_level) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (long_hit) begin
          state_d = ST_REPEAT;
          cnt_d   = '0;
        end
      end
      ST_REPEAT: begin
        if (!btn_level) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (rpt_hit) begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Release is checked before thresholds so a simultaneous threshold is dropped.
  always_comb begin
    evt_d   = EVT_NONE;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (btn_level) begin
          evt_d.press = 1'b1;
          count_d     = count_q + 8'd1;
        end
      end
      ST_PRESSED: begin
        if (!btn_level)    evt_d.rel = 1'b1;
        else if (long_hit) evt_d.lng = 1'b1;
      end
      ST_REPEAT: begin
        if (!btn_level)   evt_d.rel = 1'b1;
        else if (rpt_hit) evt_d.rpt = repeat_en;
      end
      default: evt_d = EVT_NONE;
    endcase
    held_d     = (state_d != ST_IDLE);
    long_act_d = (state_d == ST_REPEAT);
  end

  assign press_pulse   = evt_q.press;
  assign release_pulse = evt_q.rel;
  assign long_pulse    = evt_q.lng;
  assign repeat_pulse  = evt_q.rpt;
  assign held          = held_q;
  assign long_active   = long_act_q;
  assign press_count   = count_q;

endmodule
